complex_mult_seq: RTL and testbench

Operand sequencer and result collector for the team's time-shared complex multipliers (2-phase `complex_mult`, 4-phase `complex_mult4`). It accepts operand quads on a valid/ready stream and drives the multiplier's phase index. It holds each quad stable for one full frame and tracks in-flight frames. It captures each product into a small FIFO presented as a valid/ready result stream, with credit control so the FIFO can never overflow. It sits between a stream datapath and the multiplier, which is instantiated outside this block.

---
 rtl/complex_mult_pkg.sv | 32 +++
 rtl/complex_mult_seq_fifo.sv | 82 ++++++++
 rtl/complex_mult_seq.sv | 142 ++++++++++++++
 tb/tb_complex_mult_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_mult_pkg.sv
// Types and elaboration helpers shared by the time-shared complex multiplier family.
// The operand and result structs are sized by CM_WIDTH, the family's component width.
package complex_mult_pkg;

    localparam int unsigned CM_WIDTH    = 8;
    localparam int unsigned CM_PHASES_2 = 2;
    localparam int unsigned CM_PHASES_4 = 4;

    typedef struct packed {
        logic [CM_WIDTH-1:0] ar;
        logic [CM_WIDTH-1:0] ai;
        logic [CM_WIDTH-1:0] br;
        logic [CM_WIDTH-1:0] bi;
    } cm_operand_t;

    typedef struct packed {
        logic [CM_WIDTH-1:0] zr;
        logic [CM_WIDTH-1:0] zi;
    } cm_result_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) bits = bits + 1;
        return bits;
    endfunction

    function automatic bit phases_legal(input int unsigned phases);
        return (phases == CM_PHASES_2) || (phases == CM_PHASES_4);
    endfunction

endpackage

// File: rtl/complex_mult_seq_fifo.sv
// Result FIFO for complex_mult_seq: power-of-two depth, registered head output,
// push and pop allowed in the same cycle at any fill level.
module complex_mult_seq_fifo
    import complex_mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  cm_result_t             push_data_i,
    input  logic                   pop_i,
    output cm_result_t             head_o,
    output logic                   empty_o,
    output logic [clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_COUNT  = {{AW{1'b0}}, 1'b1};

    cm_result_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_next;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    cm_result_t    head_q;
    cm_result_t    head_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == FULL_COUNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    assign rd_next = rd_ptr_q + 1'b1;
    assign count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

    // The head is a register of its own so the output never sees the read mux.
    always_comb begin
        // NOTE: default first so every path assigns head_d and no latch is inferred.
        head_d = head_q;
        if (do_pop) begin
            if ((count_q != '0) && (count_q != ONE_COUNT)) begin
                head_d = mem_q[rd_next];
            end else if (do_push) begin
                head_d = push_data_i;
            end
        end else if (do_push && empty_o) begin
            head_d = push_data_i;
        end
    end

    // NOTE: storage has no reset; only pointers, count and head need a known value.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking assignments keep all state updates on the same edge.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_next;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push_i && full && !do_pop));

endmodule

// File: rtl/complex_mult_seq.sv
// Operand sequencer and result collector for the time-shared complex multipliers.
// Optional statistics counters are enabled by defining COMPLEX_MULT_SEQ_STATS_EN.
module complex_mult_seq
    import complex_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PHASES     = 4,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_ar,
    input  logic [WIDTH-1:0]          in_ai,
    input  logic [WIDTH-1:0]          in_br,
    input  logic [WIDTH-1:0]          in_bi,
    output logic [clog2(PHASES)-1:0]  mult_ind,
    output logic [WIDTH-1:0]          mult_ar,
    output logic [WIDTH-1:0]          mult_ai,
    output logic [WIDTH-1:0]          mult_br,
    output logic [WIDTH-1:0]          mult_bi,
    input  logic [WIDTH-1:0]          mult_zr,
    input  logic [WIDTH-1:0]          mult_zi,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_zr,
    output logic [WIDTH-1:0]          out_zi,
    output logic                      busy
`ifdef COMPLEX_MULT_SEQ_STATS_EN
    ,
    output logic [31:0]               stat_frames,
    output logic [31:0]               stat_stall
`endif
);

    localparam int unsigned PW = clog2(PHASES);
    localparam int unsigned CW = clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);

    if (!phases_legal(PHASES)) begin : g_bad_phases
        $error("complex_mult_seq: PHASES must be 2 or 4");
    end
    if ((LATENCY < 1) || (LATENCY > 16)) begin : g_bad_latency
        $error("complex_mult_seq: LATENCY must be 1..16");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("complex_mult_seq: FIFO_DEPTH must be a power of two >= 2");
    end
    if (WIDTH != CM_WIDTH) begin : g_bad_width
        $error("complex_mult_seq: WIDTH must match complex_mult_pkg::CM_WIDTH");
    end

    logic [PW-1:0]   p_q;
    logic [PW-1:0]   p_d;
    cm_operand_t     op_q;
    cm_operand_t     op_d;
    logic [LATENCY:0] tag_q;
    logic [LATENCY:0] tag_d;
    logic            accept;
    logic [31:0]     inflight;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    cm_result_t      fifo_head;
    cm_result_t      capture;
    logic            push;
    logic            pop;

    // Credit counts every frame that will land in the FIFO, so a push never finds it full.
    assign inflight = 32'($countones(tag_q));
    assign in_ready = (p_q == LAST_PHASE) && ((32'(fifo_count) + inflight) < FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign push     = tag_q[LATENCY];
    assign pop      = out_valid && out_ready;
    assign capture  = '{zr: mult_zr, zi: mult_zi};

    always_comb begin
        p_d   = (p_q == LAST_PHASE) ? '0 : p_q + 1'b1;
        op_d  = op_q;
        tag_d = {tag_q[LATENCY-1:0], accept};
        if (accept) op_d = '{ar: in_ar, ai: in_ai, br: in_br, bi: in_bi};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q   <= '0;
            op_q  <= '0;
            tag_q <= '0;
        end else begin
            p_q   <= p_d;
            op_q  <= op_d;
            tag_q <= tag_d;
        end
    end

    complex_mult_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (capture),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign mult_ind  = p_q;
    assign mult_ar   = op_q.ar;
    assign mult_ai   = op_q.ai;
    assign mult_br   = op_q.br;
    assign mult_bi   = op_q.bi;
    assign out_valid = !fifo_empty;
    assign out_zr    = fifo_head.zr;
    assign out_zi    = fifo_head.zi;
    assign busy      = (|tag_q) || !fifo_empty;

`ifdef COMPLEX_MULT_SEQ_STATS_EN
    logic [31:0] frames_q;
    logic [31:0] stall_q;
    logic        stall;

    assign stall = (p_q == LAST_PHASE) && in_valid && !in_ready;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_q <= '0;
            stall_q  <= '0;
        end else begin
            if (accept && (frames_q != '1)) frames_q <= frames_q + 32'd1;
            if (stall && (stall_q != '1))   stall_q  <= stall_q + 32'd1;
        end
    end

    assign stat_frames = frames_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed bench for complex_mult_seq with a 4-phase, latency-3 multiplier model.
// Also exercises the statistics counters when COMPLEX_MULT_SEQ_STATS_EN is defined.
module tb_complex_mult_seq;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned PHASES     = 4;
    localparam int unsigned LATENCY    = 3;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [7:0] ar, ai, br, bi, zr, zi;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_ar, in_ai, in_br, in_bi;
    logic [1:0] mult_ind;
    logic [7:0] mult_ar, mult_ai, mult_br, mult_bi;
    logic [7:0] mult_zr, mult_zi;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_zr, out_zi;
    logic       busy;
`ifdef COMPLEX_MULT_SEQ_STATS_EN
    logic [31:0] stat_frames;
    logic [31:0] stat_stall;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t vecs [8];

    always #5 clk = ~clk;

    complex_mult_seq #(
        .WIDTH (WIDTH), .PHASES (PHASES), .LATENCY (LATENCY), .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_ar (in_ar), .in_ai (in_ai), .in_br (in_br), .in_bi (in_bi),
        .mult_ind (mult_ind),
        .mult_ar (mult_ar), .mult_ai (mult_ai), .mult_br (mult_br), .mult_bi (mult_bi),
        .mult_zr (mult_zr), .mult_zi (mult_zi),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_zr (out_zr), .out_zi (out_zi),
        .busy (busy)
`ifdef COMPLEX_MULT_SEQ_STATS_EN
        , .stat_frames (stat_frames), .stat_stall (stat_stall)
`endif
    );

    // Multiplier model: the product of the operands seen in a phase-0 cycle is
    // presented exactly LATENCY cycles later, and filler values at all other times.
    logic       dl_v  [3];
    logic [7:0] dl_zr [3];
    logic [7:0] dl_zi [3];

    function automatic logic [15:0] cmul(input logic [7:0] ar, ai, br, bi);
        int a, b, c, d, re, im;
        a = int'($signed(ar)); b = int'($signed(ai));
        c = int'($signed(br)); d = int'($signed(bi));
        re = a * c - b * d;
        im = a * d + b * c;
        return {re[7:0], im[7:0]};
    endfunction

    always @(posedge clk) begin
        logic [15:0] prod;
        prod = cmul(mult_ar, mult_ai, mult_br, mult_bi);
        dl_v[0]  <= (mult_ind == 2'd0);
        dl_zr[0] <= prod[15:8];
        dl_zi[0] <= prod[7:0];
        for (int i = 1; i < 3; i++) begin
            dl_v[i]  <= dl_v[i-1];
            dl_zr[i] <= dl_zr[i-1];
            dl_zi[i] <= dl_zi[i-1];
        end
    end

    assign mult_zr = dl_v[2] ? dl_zr[2] : 8'hA5;
    assign mult_zi = dl_v[2] ? dl_zi[2] : 8'h3C;

    task automatic drive_vec(input int i);
        in_ar = vecs[i].ar;
        in_ai = vecs[i].ai;
        in_br = vecs[i].br;
        in_bi = vecs[i].bi;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({out_zr, out_zi} !== 16'h0000) begin
            errors++; $display("FAIL reset_out_z: got %h expected 0000", {out_zr, out_zi});
        end
        checks++;
        if ({mult_ar, mult_ai, mult_br, mult_bi, mult_ind} !== 34'h0) begin
            errors++; $display("FAIL reset_mult: got %h expected 0", {mult_ar, mult_ai, mult_br, mult_bi, mult_ind});
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({mult_ind, in_ready} !== {2'(c), (c == 3)}) begin
                errors++;
                $display("FAIL release_cycle%0d: got ind=%0d ready=%b expected ind=%0d ready=%b",
                         c, mult_ind, in_ready, c, (c == 3));
            end
            if (c < 3) @(negedge clk);
        end
    endtask

    task automatic test_single();
        int         first;
        bit         found;
        logic [7:0] zr, zi;
        drive_vec(0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 16 && !found; c++) begin
            if (in_ready) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin errors++; $display("FAIL single_accept: got no in_ready in 16 cycles expected one"); end
        first = 0; zr = '0; zi = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                in_valid = 1'b0;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
            end
            if (out_valid && first == 0) begin first = n; zr = out_zr; zi = out_zi; end
        end
        checks++;
        if (first != 5) begin errors++; $display("FAIL single_latency: got %0d expected 5", first); end
        checks++;
        if ({zr, zi} !== 16'h05FF) begin errors++; $display("FAIL single_result: got %h expected 05ff", {zr, zi}); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL single_drained: got valid/busy=%b expected 00", {out_valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, last_acc;
        bit acc;
        sent = 0; got = 0; last_acc = 0;
        out_ready = 1'b1;
        drive_vec(0);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            acc = in_valid && in_ready;
            if (acc) begin
                if (sent > 0) begin
                    checks++;
                    if (cyc - last_acc != 4) begin
                        errors++; $display("FAIL b2b_spacing%0d: got %0d cycles expected 4", sent, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got >= 8) begin
                    errors++; $display("FAIL b2b_extra: got result %0d expected only 8", got);
                end else if ({out_zr, out_zi} !== {vecs[got].zr, vecs[got].zi}) begin
                    errors++; $display("FAIL b2b_result%0d: got %h expected %h", got, {out_zr, out_zi},
                                       {vecs[got].zr, vecs[got].zi});
                end
                got++;
            end
            @(negedge clk);
            if (acc) begin
                if (sent < 8) drive_vec(sent);
                else in_valid = 1'b0;
            end
        end
        checks++;
        if ({sent, got} != {32'd8, 32'd8}) begin
            errors++; $display("FAIL b2b_count: got sent=%0d results=%0d expected 8 and 8", sent, got);
        end
    endtask

    task automatic test_backpressure();
        int sent, got;
        bit acc;
        sent = 0; got = 0;
        out_ready = 1'b0;
        drive_vec(0);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(negedge clk);
            if (acc) drive_vec(sent % 8);
        end
        checks++;
        if (sent != FIFO_DEPTH) begin errors++; $display("FAIL bp_accepts: got %0d expected %0d", sent, FIFO_DEPTH); end
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b110) begin
            errors++; $display("FAIL bp_full_state: got valid/busy/ready=%b expected 110", {out_valid, busy, in_ready});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid) begin
                checks++;
                if (got >= 4) begin
                    errors++; $display("FAIL bp_extra: got result %0d expected only 4", got);
                end else if ({out_zr, out_zi} !== {vecs[got].zr, vecs[got].zi}) begin
                    errors++; $display("FAIL bp_drain%0d: got %h expected %h", got, {out_zr, out_zi},
                                       {vecs[got].zr, vecs[got].zi});
                end
                got++;
            end
            @(negedge clk);
        end
        checks++;
        if (got != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", got); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_midway();
        int         sent, acc_cycle, first;
        bit         acc;
        logic [7:0] zr, zi;
        sent = 0;
        out_ready = 1'b0;
        drive_vec(0);
        in_valid = 1'b1;
        for (int c = 0; c < 40 && sent < 2; c++) begin
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent == 1) drive_vec(1);
                else in_valid = 1'b0;
            end
        end
        checks++;
        if ({sent, out_valid, busy} !== {32'd2, 2'b11}) begin
            errors++; $display("FAIL midrst_pre: got sent=%0d valid=%b busy=%b expected 2 1 1", sent, out_valid, busy);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            errors++; $display("FAIL midrst_flags: got valid/busy/ready=%b expected 000", {out_valid, busy, in_ready});
        end
        checks++;
        if ({mult_ind, mult_ar, mult_ai, mult_br, mult_bi, out_zr, out_zi} !== 50'h0) begin
            errors++; $display("FAIL midrst_regs: got %h expected 0",
                               {mult_ind, mult_ar, mult_ai, mult_br, mult_bi, out_zr, out_zi});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_vec(5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc_cycle = -1;
        for (int c = 0; c < 8 && acc_cycle < 0; c++) begin
            if (in_ready) acc_cycle = c;
            else @(negedge clk);
        end
        checks++;
        if (acc_cycle != 3) begin errors++; $display("FAIL midrst_first_accept: got cycle %0d expected 3", acc_cycle); end
        first = 0; zr = '0; zi = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) in_valid = 1'b0;
            if (out_valid && first == 0) begin first = n; zr = out_zr; zi = out_zi; end
        end
        checks++;
        if (first != 5) begin errors++; $display("FAIL midrst_latency: got %0d expected 5", first); end
        checks++;
        if ({zr, zi} !== 16'h8000) begin errors++; $display("FAIL midrst_result: got %h expected 8000", {zr, zi}); end
    endtask

`ifdef COMPLEX_MULT_SEQ_STATS_EN
    task automatic test_stats();
        int frames, stalls;
        bit acc;
        frames = 0; stalls = 0;
        in_valid = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        drive_vec(0);
        in_valid = 1'b1;
        for (int c = 0; c < 200 && stalls < 6; c++) begin
            acc = in_valid && in_ready;
            if (acc) frames++;
            if (mult_ind == 2'd3 && in_valid && !in_ready) stalls++;
            @(negedge clk);
            if (acc) drive_vec(frames % 8);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b1;
        for (int c = 0; c < 200 && frames < 10; c++) begin
            acc = in_valid && in_ready;
            if (acc) frames++;
            @(negedge clk);
            if (acc) drive_vec(frames % 8);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({frames, stalls} != {32'd10, 32'd6}) begin
            errors++; $display("FAIL stats_stimulus: got frames=%0d stalls=%0d expected 10 and 6", frames, stalls);
        end
        checks++;
        if (stat_frames !== 32'd10) begin errors++; $display("FAIL stat_frames: got %0d expected 10", stat_frames); end
        checks++;
        if (stat_stall !== 32'd6) begin errors++; $display("FAIL stat_stall: got %0d expected 6", stat_stall); end
    endtask
`endif

    initial begin
        vecs[0] = '{8'h03, 8'h02, 8'h01, 8'hFF, 8'h05, 8'hFF};
        vecs[1] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
        vecs[2] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'hF9, 8'h16};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00};
        vecs[4] = '{8'h0A, 8'hFC, 8'h06, 8'h07, 8'h58, 8'h2E};
        vecs[5] = '{8'h80, 8'h00, 8'hFF, 8'h00, 8'h80, 8'h00};
        vecs[6] = '{8'h7F, 8'h01, 8'h02, 8'h00, 8'hFE, 8'h02};
        vecs[7] = '{8'hFB, 8'h07, 8'hFD, 8'hFE, 8'h1D, 8'hF5};
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ar = '0; in_ai = '0; in_br = '0; in_bi = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midway();
`ifdef COMPLEX_MULT_SEQ_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units expected earlier finish");
        $fatal(1);
    end

endmodule
